// File: rtl/aes_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : aes_pkg
// Brief   : Shared AES-128 key-schedule constants, FSM state type, rcon step.
// Revision: 1.0
//------------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_NR   = 10;
   localparam int RK_BUS_W = 128 * (AES_NR + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   // Multiply by x in GF(2^8), reduced by the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : aes_sbox
// Brief   : Combinational AES forward S-box, one byte in, one byte out.
// Revision: 1.0
//------------------------------------------------------------------------------
module aes_sbox (
   input  logic [7:0] data_i,
   output logic [7:0] data_o
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign data_o = SBOX[data_i];

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : aes_key_schedule_seq
// Brief   : Sequential AES-128 key expansion, one round key per clock.
// Revision: 1.0
//------------------------------------------------------------------------------
module aes_key_schedule_seq
   import aes_pkg::*;
#(
   parameter int NR = AES_NR
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [127:0]            key_in,
   input  logic                    key_valid,
   output logic                    key_ready,
   output logic                    busy,
   output logic                    done,
   output logic                    keys_valid,
   output logic [128*(NR+1)-1:0]   round_keys,
   input  logic [3:0]              rk_idx,
   output logic [127:0]            rk_out
);

   state_e        state_q, state_d;
   logic [3:0]    rnd_q, rnd_d;
   logic [7:0]    rcon_q, rcon_d;
   logic          done_q, done_d;
   logic [127:0]  store_q [0:NR];

   logic          w_accept;
   logic          w_last;
   logic [127:0]  w_prev;
   logic [31:0]   w_rot;
   logic [31:0]   w_sub;
   logic [31:0]   w_nw0, w_nw1, w_nw2, w_nw3;
   logic [127:0]  w_next;

   assign key_ready  = (state_q != ST_EXPAND);
   assign busy       = (state_q == ST_EXPAND);
   assign keys_valid = (state_q == ST_DONE);
   assign done       = done_q;
   assign w_accept   = key_valid & key_ready;
   assign w_last     = (rnd_q == 4'(NR));

   // Key feeding the round currently being produced.
   always_comb begin
      w_prev = store_q[0];
      for (int k = 1; k <= NR; k++) begin
         if (rnd_q == 4'(k)) begin
            w_prev = store_q[k-1];
         end
      end
   end

   assign w_rot = {w_prev[23:0], w_prev[31:24]};

   generate
      for (genvar i = 0; i < 4; i++) begin : g_subword
         aes_sbox u_sbox (
            .data_i (w_rot[8*i +: 8]),
            .data_o (w_sub[8*i +: 8])
         );
      end
   endgenerate

   assign w_nw0  = w_prev[127:96] ^ w_sub ^ {rcon_q, 24'h0};
   assign w_nw1  = w_prev[95:64]  ^ w_nw0;
   assign w_nw2  = w_prev[63:32]  ^ w_nw1;
   assign w_nw3  = w_prev[31:0]   ^ w_nw2;
   assign w_next = {w_nw0, w_nw1, w_nw2, w_nw3};

   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      rcon_d  = rcon_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (w_accept) begin
               state_d = ST_EXPAND;
               rnd_d   = 4'd1;
               rcon_d  = 8'h01;
            end
         end
         ST_EXPAND: begin
            rcon_d = xtime(rcon_q);
            if (w_last) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               rnd_d = rnd_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rnd_q   <= 4'd0;
         rcon_q  <= 8'h01;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         rcon_q  <= rcon_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k <= NR; k++) begin
            store_q[k] <= 128'h0;
         end
      end else begin
         if (w_accept) begin
            store_q[0] <= key_in;
         end
         if (state_q == ST_EXPAND) begin
            for (int k = 1; k <= NR; k++) begin
               if (rnd_q == 4'(k)) begin
                  store_q[k] <= w_next;
               end
            end
         end
      end
   end

   generate
      for (genvar k = 0; k <= NR; k++) begin : g_flat
         assign round_keys[128*k +: 128] = store_q[k];
      end
   endgenerate

   // Indices past the last round read as zero.
   always_comb begin
      rk_out = 128'h0;
      for (int k = 0; k <= NR; k++) begin
         if (rk_idx == 4'(k)) begin
            rk_out = store_q[k];
         end
      end
   end

endmodule
`default_nettype wire
